// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: frames UART bytes (sync, op, A, B, checksum) into one validated command
module uart_cmd_sequencer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 208_333,
    parameter int         TO_W           = 18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_a,
    output logic [15:0] cmd_b,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, OP, A_HI, A_LO, B_HI, B_LO, CHK, HOLD} state_t;
    state_t state;
    logic rx_done_q, ev, in_frame, op_ok, expire;
    logic [7:0] byte_q, chk, op_s;
    logic [15:0] a_s, b_s;
    logic [TO_W-1:0] to_cnt;
    assign in_frame = state != IDLE && state != HOLD;
    assign op_ok    = byte_q inside {8'h2B, 8'h2D, 8'h2A, 8'h2F};
    assign expire   = in_frame && !ev && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign busy     = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rx_done_q <= 1'b0;
            ev        <= 1'b0;
            byte_q    <= '0;
            chk       <= '0;
            op_s      <= '0;
            a_s       <= '0;
            b_s       <= '0;
            to_cnt    <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
        end else begin
            rx_done_q <= rx_done;
            ev        <= rx_done & ~rx_done_q;
            if (rx_done & ~rx_done_q) byte_q <= rx_data;
            err_pulse <= 1'b0;
            to_cnt    <= (in_frame && !ev) ? to_cnt + 1'b1 : '0;
            case (state)
                IDLE: if (ev && byte_q == SYNC_BYTE) begin
                    state <= OP;
                    chk   <= '0;
                end
                OP: if (ev) begin
                    if (op_ok) begin
                        op_s  <= byte_q;
                        chk   <= chk ^ byte_q;
                        state <= A_HI;
                    end else begin
                        err_pulse <= 1'b1;
                        err_code  <= 2'd1;
                        state     <= IDLE;
                    end
                end
                A_HI: if (ev) begin
                    a_s[15:8] <= byte_q;
                    chk       <= chk ^ byte_q;
                    state     <= A_LO;
                end
                A_LO: if (ev) begin
                    a_s[7:0] <= byte_q;
                    chk      <= chk ^ byte_q;
                    state    <= B_HI;
                end
                B_HI: if (ev) begin
                    b_s[15:8] <= byte_q;
                    chk       <= chk ^ byte_q;
                    state     <= B_LO;
                end
                B_LO: if (ev) begin
                    b_s[7:0] <= byte_q;
                    chk      <= chk ^ byte_q;
                    state    <= CHK;
                end
                CHK: if (ev) begin
                    if (byte_q == chk) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= op_s;
                        cmd_a     <= a_s;
                        cmd_b     <= b_s;
                        state     <= HOLD;
                    end else begin
                        err_pulse <= 1'b1;
                        err_code  <= 2'd2;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (ev) begin
                        err_pulse <= 1'b1;
                        err_code  <= 2'd3;
                    end
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // expire never coincides with a byte event, so it cannot clash with the case above
            if (expire) begin
                err_pulse <= 1'b1;
                err_code  <= 2'd0;
                to_cnt    <= '0;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed frames with an expected-event queue checked by a monitor
module tb_uart_cmd_sequencer;
    localparam int TO = 12000;
    logic clk = 1'b0, reset_n = 1'b0, rx_done = 1'b0, cmd_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic cmd_valid, err_pulse, busy;
    logic [7:0] cmd_op;
    logic [15:0] cmd_a, cmd_b;
    logic [1:0] err_code;
    int n_cmp = 0, n_bad = 0;
    typedef struct {bit is_err; logic [1:0] code; logic [7:0] op; logic [15:0] a, b;} exp_t;
    exp_t q[$];
    exp_t e;
    uart_cmd_sequencer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(14)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
        .cmd_b(cmd_b), .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (reset_n) begin
        if (err_pulse) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_err: got code %0d, expected no event", err_code);
            end else begin
                e = q.pop_front();
                if (!e.is_err || err_code !== e.code) begin
                    n_bad++;
                    $display("FAIL err_event: got err code %0d, expected is_err=%0d code %0d", err_code, e.is_err, e.code);
                end
            end
        end
        if (cmd_valid && cmd_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cmd: got %h/%h/%h, expected no event", cmd_op, cmd_a, cmd_b);
            end else begin
                e = q.pop_front();
                if (e.is_err || {cmd_op, cmd_a, cmd_b} !== {e.op, e.a, e.b}) begin
                    n_bad++;
                    $display("FAIL cmd_event: got %h/%h/%h, expected is_err=%0d %h/%h/%h", cmd_op, cmd_a, cmd_b, e.is_err, e.op, e.a, e.b);
                end
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic push_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        q.push_back('{is_err: 1'b0, code: 2'd0, op: op, a: a, b: b});
    endtask
    task automatic push_err(input logic [1:0] code);
        q.push_back('{is_err: 1'b1, code: code, op: 8'h00, a: 16'h0, b: 16'h0});
    endtask
    task automatic send_byte(input logic [7:0] b, input int hold = 1, input int gap = 3);
        rx_data = b;
        rx_done = 1'b1;
        tick(hold);
        rx_done = 1'b0;
        tick(gap);
    endtask
    task automatic send_frame(input logic [55:0] f);
        for (int i = 0; i < 7; i++) send_byte(f[55-8*i -: 8]);
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 40'(cmd_valid), 40'd0);
        check({tag, "_op"}, 40'(cmd_op), 40'd0);
        check({tag, "_a"}, 40'(cmd_a), 40'd0);
        check({tag, "_b"}, 40'(cmd_b), 40'd0);
        check({tag, "_err_pulse"}, 40'(err_pulse), 40'd0);
        check({tag, "_err_code"}, 40'(err_code), 40'd0);
        check({tag, "_busy"}, 40'(busy), 40'd0);
    endtask
    initial begin
        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(2);
        // good frame, first-cycle acceptance and two-cycle latency
        cmd_ready = 1'b1;
        push_cmd(8'h2B, 16'h0012, 16'h0034);
        for (int i = 0; i < 6; i++) send_byte(i == 0 ? 8'hA5 : i == 1 ? 8'h2B : i == 3 ? 8'h12 : i == 5 ? 8'h34 : 8'h00);
        rx_data = 8'h0D;
        rx_done = 1'b1;
        tick(1);
        check("latency_1cyc", 40'(cmd_valid), 40'd0);
        tick(1);
        check("latency_2cyc", 40'(cmd_valid), 40'd1);
        rx_done = 1'b0;
        tick(3);
        check("t1_valid_drop", 40'(cmd_valid), 40'd0);
        check("t1_idle", 40'(busy), 40'd0);
        // bad checksum
        push_err(2'd2);
        send_frame(56'hA5_2B_00_12_00_34_0E);
        tick(3);
        check("t2_err_code", 40'(err_code), 40'd2);
        check("t2_no_valid", 40'(cmd_valid), 40'd0);
        check("t2_idle", 40'(busy), 40'd0);
        // inter-byte timeout, then recovery
        push_err(2'd0);
        send_byte(8'hA5);
        send_byte(8'h2B);
        send_byte(8'h00);
        check("t3_busy", 40'(busy), 40'd1);
        tick(TO + 20);
        check("t3_err_code", 40'(err_code), 40'd0);
        check("t3_idle", 40'(busy), 40'd0);
        push_cmd(8'h2D, 16'h1234, 16'h0005);
        send_frame(56'hA5_2D_12_34_00_05_0E);
        // junk ignored, bad opcode
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t4_junk_idle", 40'(busy), 40'd0);
        push_err(2'd1);
        send_byte(8'hA5);
        send_byte(8'h41);
        tick(2);
        check("t4_err_code", 40'(err_code), 40'd1);
        check("t4_idle", 40'(busy), 40'd0);
        // sync value as payload, and the multiply opcode
        push_cmd(8'h2F, 16'hA5A5, 16'h00A5);
        send_frame(56'hA5_2F_A5_A5_00_A5_8A);
        push_cmd(8'h2A, 16'hFFFF, 16'h0002);
        send_frame(56'hA5_2A_FF_FF_00_02_28);
        tick(3);
        // overrun while holding a command
        cmd_ready = 1'b0;
        push_err(2'd3);
        push_cmd(8'h2B, 16'h0012, 16'h0034);
        send_frame(56'hA5_2B_00_12_00_34_0D);
        tick(2);
        check("t5_valid", 40'(cmd_valid), 40'd1);
        send_byte(8'h55);
        tick(2);
        check("t5_err_code", 40'(err_code), 40'd3);
        check("t5_hold_cmd", {cmd_op, cmd_a, cmd_b}, 40'h2B_0012_0034);
        check("t5_still_valid", 40'(cmd_valid), 40'd1);
        check("t5_busy", 40'(busy), 40'd1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(3);
        check("t5_valid_drop", 40'(cmd_valid), 40'd0);
        check("t5_idle", 40'(busy), 40'd0);
        // long rx_done levels, then reset mid-frame
        send_byte(8'hA5, 10000, 3);
        send_byte(8'h2B, 10000, 3);
        send_byte(8'h00, 10000, 3);
        check("t6_busy_mid", 40'(busy), 40'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        tick(2);
        reset_n = 1'b1;
        tick(2);
        cmd_ready = 1'b1;
        push_cmd(8'h2B, 16'h0012, 16'h0034);
        send_frame(56'hA5_2B_00_12_00_34_0D);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got nothing, expected is_err=%0d code %0d cmd %h/%h/%h", e.is_err, e.code, e.op, e.a, e.b);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
